t03_instruction_encoder: RTL and testbench

Packs RV32I instruction fields into 32-bit machine words and streams them into instruction memory. Its op set and encodings match exactly the set that `t03_control_logic_unit` decodes. It is the program-load path that fills instruction memory before the core is released. Fields arrive over a valid/ready handshake and pass through a registered encode stage and a 2-deep word FIFO. A memory write port then writes each word at an auto-incrementing word address.

---
 rtl/t03_instruction_encoder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_t03_instruction_encoder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_instruction_encoder.sv
// t03_instruction_encoder
//
// Program-load path for instruction memory. Each accepted instruction-field
// record is encoded into an RV32I machine word. The op set matches
// t03_control_logic_unit. The word is held in a one-entry encode stage, then
// queued in a 2-deep word FIFO. It is written to memory at an
// auto-incrementing word address.
//
// Parameters
//   ADDR_W     instruction memory word-address width
//   BASE_ADDR  first word address written after start
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin/restart a load (flushes the pipeline)
//   in_valid / in_ready      field handshake
//   in_op, in_rd, in_rs1,
//   in_rs2, in_imm, in_last  instruction fields; in_last marks the final one
//   mem_wr_en, mem_addr,
//   mem_wdata, mem_ack       memory write port
//   busy, done, err          status (err is sticky until start/rst)
//   dbg_state                current FSM state (IDLE=0 LOAD=1 DRAIN=2 DONE=3)
//   checksum                 XOR of all written words since start
//                            (present only with T03_ENCODER_CHECKSUM_EN)
//
// Handshake semantics: a field transfers on a rising edge where
// in_valid && in_ready && !start. A memory write completes on a rising edge
// where mem_wr_en && mem_ack. While mem_wr_en is high, mem_addr and
// mem_wdata hold their values until the write completes.
//
// Optional feature macro: T03_ENCODER_CHECKSUM_EN
module t03_instruction_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
`ifdef T03_ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_ONE  = ADDR_W'(1);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Returns {err, word}. err flags an invalid op or an odd branch/jump offset.
  function automatic logic [32:0] f_encode(
    input logic [5:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    w  = NOP_WORD;
    e  = 1'b0;
    f3 = 3'd0;
    f7 = 7'h00;
    if (op <= 6'd9) begin
      case (op)
        6'd0:    f3 = 3'd0; // add
        6'd1:    f3 = 3'd0; // sub
        6'd2:    f3 = 3'd4; // xor
        6'd3:    f3 = 3'd6; // or
        6'd4:    f3 = 3'd7; // and
        6'd5:    f3 = 3'd1; // sll
        6'd6:    f3 = 3'd5; // srl
        6'd7:    f3 = 3'd5; // sra
        6'd8:    f3 = 3'd2; // slt
        default: f3 = 3'd3; // sltu
      endcase
      f7 = (op == 6'd1 || op == 6'd7) ? 7'h20 : 7'h00;
      w  = {f7, rs2, rs1, f3, rd, OPC_R};
    end else if (op <= 6'd11) begin
      f3 = (op == 6'd10) ? 3'd0 : 3'd2;
      w  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
    end else if (op <= 6'd20) begin
      case (op)
        6'd12:   f3 = 3'd0; // addi
        6'd13:   f3 = 3'd1; // slli
        6'd14:   f3 = 3'd2; // slti
        6'd15:   f3 = 3'd3; // sltiu
        6'd16:   f3 = 3'd4; // xori
        6'd17:   f3 = 3'd5; // srli
        6'd18:   f3 = 3'd5; // srai
        6'd19:   f3 = 3'd6; // ori
        default: f3 = 3'd7; // andi
      endcase
      if (op == 6'd13 || op == 6'd17 || op == 6'd18) begin
        // Shift-immediates carry funct7 in imm[11:5]; only shamt comes from in_imm.
        f7 = (op == 6'd18) ? 7'h20 : 7'h00;
        w  = {f7, imm[4:0], rs1, f3, rd, OPC_IMM};
      end else begin
        w  = {imm[11:0], rs1, f3, rd, OPC_IMM};
      end
    end else if (op <= 6'd22) begin
      f3 = (op == 6'd21) ? 3'd0 : 3'd2;
      w  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    end else if (op == 6'd23) begin
      w  = {imm[31:12], rd, OPC_LUI};
    end else if (op == 6'd24) begin
      w  = {imm[31:12], rd, OPC_AUIPC};
    end else if (op <= 6'd30) begin
      case (op)
        6'd25:   f3 = 3'd0; // beq
        6'd26:   f3 = 3'd1; // bne
        6'd27:   f3 = 3'd4; // blt
        6'd28:   f3 = 3'd5; // bge
        6'd29:   f3 = 3'd6; // bltu
        default: f3 = 3'd7; // bgeu
      endcase
      w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BR};
      e  = imm[0];
    end else if (op == 6'd31) begin
      w  = {imm[11:0], rs1, 3'd0, rd, OPC_JALR};
    end else if (op == 6'd32) begin
      w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      e  = imm[0];
    end else begin
      w  = NOP_WORD;
      e  = 1'b1;
    end
    return {e, w};
  endfunction

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic              r_enc_valid;
  logic [31:0]       r_enc_word;
  logic [31:0]       r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_cnt;

  logic        w_fifo_full;
  logic        w_pop;
  logic        w_push;
  logic        w_can_adv;
  logic        w_accept;
  logic [32:0] w_enc;

  assign w_fifo_full = (r_cnt == 2'd2);
  assign w_pop       = (r_cnt != 2'd0) && mem_ack;
  // The encode stage may advance if the FIFO has room, counting a same-cycle pop.
  assign w_can_adv   = !w_fifo_full || w_pop;
  assign w_push      = r_enc_valid && w_can_adv;
  assign w_accept    = in_valid && in_ready && !start;
  assign w_enc       = f_encode(in_op, in_rd, in_rs1, in_rs2, in_imm);

  assign in_ready  = (r_state == S_LOAD) && w_can_adv;
  assign mem_wr_en = (r_cnt != 2'd0);
  assign mem_addr  = r_addr;
  assign mem_wdata = (r_cnt != 2'd0) ? r_fifo[r_rd_ptr] : 32'h0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

  // Encode stage and word FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_valid <= 1'b0;
      r_enc_word  <= 32'h0;
      r_fifo[0]   <= 32'h0;
      r_fifo[1]   <= 32'h0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
    end else if (start) begin
      r_enc_valid <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_enc_word;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_accept) begin
        r_enc_valid <= 1'b1;
        r_enc_word  <= w_enc[31:0];
      end else if (w_push) begin
        r_enc_valid <= 1'b0;
      end
    end
  end

  // Address counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= L_BASE;
      r_err  <= 1'b0;
    end else if (start) begin
      r_addr <= L_BASE;
      r_err  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + L_ONE;
      end
      // Writing the top address wraps the counter to 0, which is flagged.
      r_err <= r_err | (w_pop && (r_addr == '1)) | (w_accept && w_enc[32]);
    end
  end

  // Load sequencing FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (start) begin
      r_state <= S_LOAD;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept && in_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_enc_valid && (r_cnt == 2'd0)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

`ifdef T03_ENCODER_CHECKSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= 32'h0;
    end else if (start) begin
      r_csum <= 32'h0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ mem_wdata;
    end
  end

  assign checksum = r_csum;
`endif

endmodule

// File: tb/tb_t03_instruction_encoder.sv
module tb_t03_instruction_encoder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  logic        in_ready_b;
  logic        mem_wr_en_b;
  logic [1:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic        busy_b;
  logic        done_b;
  logic        err_b;
  logic [1:0]  dbg_state_b;
`ifdef T03_ENCODER_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] checksum_b;
`endif

  t03_instruction_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
`ifdef T03_ENCODER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // Narrow-address instance for the wrap-around case; shares all stimulus.
  t03_instruction_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w2 (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_ack(mem_ack),
    .busy(busy_b), .done(done_b), .err(err_b), .dbg_state(dbg_state_b)
`ifdef T03_ENCODER_CHECKSUM_EN
    , .checksum(checksum_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_errors;
  int          exp_addr;
  logic [31:0] exp_q[$];
  logic [7:0]  expa_q[$];
  logic [1:0]  got2_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_wr_en && mem_ack) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", exp_q.size(), 1);
      end else begin
        check_eq("wr_data", mem_wdata, exp_q.pop_front());
        check_eq("wr_addr", {24'h0, mem_addr}, {24'h0, expa_q.pop_front()});
      end
    end
    if (!rst && mem_wr_en_b && mem_ack) begin
      got2_q.push_back(mem_addr_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_w);
    int n;
    exp_q.push_back(exp_w);
    expa_q.push_back(8'(exp_addr));
    exp_addr++;
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("accept_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] wrap_w [5];
    logic [31:0] rec_w;
    logic        have_rec;
    logic        stable;
    int          acc;
    int          idx;
    logic [5:0]  bp_op  [4];
    logic [4:0]  bp_rd  [4];
    logic [4:0]  bp_rs1 [4];
    logic [4:0]  bp_rs2 [4];
    logic [31:0] bp_imm [4];
    logic [31:0] bp_w   [3];
    logic        no_wr;

    n_checks = 0;
    n_errors = 0;
    exp_addr = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_op    = 6'd0;
    in_rd    = 5'd0;
    in_rs1   = 5'd0;
    in_rs2   = 5'd0;
    in_imm   = 32'h0;
    in_last  = 1'b0;
    mem_ack  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_wr_en", mem_wr_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_in_ready", in_ready, 0);

    // Basic encodes with latency check on the first word
    mem_ack = 1'b1;
    do_start();
    check_eq("start_busy", busy, 1);
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h003100B3);
    @(negedge clk);
    check_eq("lat_enc_only", mem_wr_en, 0);
    @(negedge clk);
    check_eq("lat_wr_en", mem_wr_en, 1);
    @(posedge clk); #1;
    send(6'd12, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293);
    send(6'd18, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 32'h4030D093);
    wait_drain();
    check_eq("basic_err", err, 0);
`ifdef T03_ENCODER_CHECKSUM_EN
    check_eq("csum_basic", checksum, 32'h003100B3 ^ 32'hFFF00293 ^ 32'h4030D093);
    do_start();
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h003100B3);
    send(6'd12, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293);
    wait_drain();
    check_eq("csum_two", checksum, 32'h003100B3 ^ 32'hFFF00293);
`endif

    // Start with a simultaneous field: the field is dropped
    in_valid = 1'b1;
    in_op    = 6'd0;
    in_rd    = 5'd7;
    do_start();
    in_valid = 1'b0;
    no_wr = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_wr_en) no_wr = 1'b0;
    end
    check_eq("start_wins", no_wr, 1);
    @(posedge clk); #1;

    // Store and branch
    send(6'd22, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020A423);
    send(6'd25, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00208463);
    wait_drain();

    // Upper immediate and jump, ending the load
    do_start();
    send(6'd23, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'h123450B7);
    send(6'd32, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h010000EF);
    wait_drain();
    @(posedge clk); #1;
    check_eq("done_high", done, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_state", dbg_state, 3);
    check_eq("done_in_ready", in_ready, 0);

    // Backpressure: no acks, field valid held
    bp_op[0] = 6'd16; bp_rd[0] = 5'd3;  bp_rs1[0] = 5'd4;  bp_rs2[0] = 5'd0;  bp_imm[0] = 32'h0000_000F;
    bp_op[1] = 6'd19; bp_rd[1] = 5'd6;  bp_rs1[1] = 5'd7;  bp_rs2[1] = 5'd0;  bp_imm[1] = 32'hFFFF_FFF0;
    bp_op[2] = 6'd9;  bp_rd[2] = 5'd10; bp_rs1[2] = 5'd11; bp_rs2[2] = 5'd12; bp_imm[2] = 32'h0;
    bp_op[3] = 6'd11; bp_rd[3] = 5'd1;  bp_rs1[3] = 5'd2;  bp_rs2[3] = 5'd0;  bp_imm[3] = 32'd4;
    bp_w[0] = 32'h00F24193;
    bp_w[1] = 32'hFF03E313;
    bp_w[2] = 32'h00C5B533;
    mem_ack = 1'b0;
    do_start();
    acc = 0; idx = 0; have_rec = 1'b0; stable = 1'b1; rec_w = 32'h0;
    in_valid = 1'b1;
    in_op = bp_op[0]; in_rd = bp_rd[0]; in_rs1 = bp_rs1[0]; in_rs2 = bp_rs2[0]; in_imm = bp_imm[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr_en) begin
        if (!have_rec) begin
          rec_w    = mem_wdata;
          have_rec = 1'b1;
        end else if (mem_wdata !== rec_w) begin
          stable = 1'b0;
        end
      end
      if (in_ready) begin
        if (idx < 3) begin
          exp_q.push_back(bp_w[idx]);
          expa_q.push_back(8'(exp_addr));
          exp_addr++;
        end
        acc++;
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) begin
        in_op = bp_op[idx]; in_rd = bp_rd[idx]; in_rs1 = bp_rs1[idx];
        in_rs2 = bp_rs2[idx]; in_imm = bp_imm[idx];
      end
    end
    check_eq("bp_accepted", acc, 3);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_wr_pending", mem_wr_en, 1);
    check_eq("bp_head_word", rec_w, 32'h00F24193);
    check_eq("bp_wdata_stable", stable, 1);
    in_valid = 1'b0;
    mem_ack  = 1'b1;
    wait_drain();

    // Error paths
    do_start();
    send(6'd40, 5'd3, 5'd4, 5'd5, 32'h0000_0123, 1'b0, 32'h00000013);
    wait_drain();
    check_eq("err_invalid_op", err, 1);
    do_start();
    check_eq("start_clears_err", err, 0);
    send(6'd25, 5'd0, 5'd1, 5'd2, 32'd9, 1'b0, 32'h00208463);
    wait_drain();
    check_eq("err_odd_branch", err, 1);

    // Address wrap on the 2-bit instance
    wrap_w[0] = 32'h00100093;
    wrap_w[1] = 32'h00200113;
    wrap_w[2] = 32'h00300193;
    wrap_w[3] = 32'h00400213;
    wrap_w[4] = 32'h00500293;
    do_start();
    check_eq("wrap_err_clear", err_b, 0);
    got2_q.delete();
    for (int i = 1; i <= 5; i++) begin
      send(6'd12, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0, wrap_w[i-1]);
    end
    wait_drain();
    check_eq("wrap_count", got2_q.size(), 5);
    check_eq("wrap_addr3", (got2_q.size() > 3) ? got2_q[3] : 2'd0, 3);
    check_eq("wrap_addr4", (got2_q.size() > 4) ? got2_q[4] : 2'd3, 0);
    check_eq("wrap_err", err_b, 1);
    check_eq("wrap_next_addr", mem_addr_b, 1);
    check_eq("nowrap_err", err, 0);

    // Reset while the FIFO holds two words
    mem_ack = 1'b0;
    do_start();
    send(6'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 32'h003100B3);
    send(6'd12, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293);
    @(posedge clk); #1;
    check_eq("pre_rst_full", in_ready, 0);
    check_eq("pre_rst_wr_en", mem_wr_en, 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    expa_q.delete();
    check_eq("mid_rst_wr_en", mem_wr_en, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr", mem_addr, 0);
    check_eq("mid_rst_wdata", mem_wdata, 0);
    check_eq("mid_rst_state", dbg_state, 0);
`ifdef T03_ENCODER_CHECKSUM_EN
    check_eq("mid_rst_csum", checksum, 0);
`endif
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_wr_en", mem_wr_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    no_wr = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_wr_en) no_wr = 1'b0;
    end
    check_eq("post_rst_no_write", no_wr, 1);
    check_eq("post_rst_idle", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
